ysyx_23060061_core_ctrl: RTL and testbench
==========================================

YSYX_23060061_CORE_CTRL -- requirements
Module: ysyx_23060061_core_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of stalled cycles in one wait state before a bus error (used only with YSYX_23060061_BUS_TIMEOUT_EN).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port if_req_valid, output, 1 bit: instruction fetch request at the current PC.
REQ-006 SHALL have port if_req_ready, input, 1 bit: instruction memory accepts the request.
REQ-007 SHALL have port if_resp_valid, input, 1 bit: instruction word is available.
REQ-008 SHALL have port inst_we, output, 1 bit: latch the instruction register.
REQ-009 SHALL have port mem_rw, input, 2 bits: decoder memory class; 00 none, 10 load, 01 store, 11 illegal.
REQ-010 SHALL have port reg_write, input, 1 bit: decoder register-write flag.
REQ-011 SHALL have port ebreak, input, 1 bit: decoder ebreak flag.
REQ-012 SHALL have port lsu_req_valid, output, 1 bit: data memory request.
REQ-013 SHALL have port lsu_we, output, 1 bit: 1 for a store, 0 for a load; valid while lsu_req_valid is high.
REQ-014 SHALL have port lsu_req_ready, input, 1 bit: data memory accepts the request.
REQ-015 SHALL have port lsu_resp_valid, input, 1 bit: load data ready or store done.
REQ-016 SHALL have port rf_we, output, 1 bit: register file write enable.
REQ-017 SHALL have port pc_we, output, 1 bit: PC update enable.
REQ-018 SHALL have port halt, output, 1 bit: core stopped by ebreak.
REQ-019 SHALL have port err, output, 1 bit: core stopped by an illegal mem_rw or a timeout.
REQ-020 SHALL have port state, output, 3 bits: current FSM state encoding, for debug.

Function
REQ-021 SHALL implement a Moore FSM with these encodings: FETCH=0, WAIT_I=1, EXEC=2, MEM_REQ=3, MEM_WAIT=4, WB=5, HALT=6, ERR=7.
REQ-022 SHALL, in FETCH, assert if_req_valid and go to WAIT_I in the cycle if_req_ready is sampled high; otherwise it stays in FETCH.
REQ-023 SHALL, in WAIT_I, assert inst_we only in the cycle if_resp_valid is high, then go to EXEC.
REQ-024 SHALL spend exactly one cycle in EXEC, with priority ebreak -> HALT, then mem_rw==11 -> ERR, then mem_rw 10 or 01 -> MEM_REQ, else -> WB.
REQ-025 SHALL register lsu_we from mem_rw[0] on leaving EXEC and hold it stable until WB.
REQ-026 SHALL, in MEM_REQ, assert lsu_req_valid and go to MEM_WAIT when lsu_req_ready is high; lsu_req_valid SHALL NOT drop before that handshake.
REQ-027 SHALL, in MEM_WAIT, go to WB when lsu_resp_valid is high; a lsu_resp_valid seen in any other state SHALL be ignored.
REQ-028 SHALL, in WB, drive pc_we=1 and rf_we=reg_write for exactly one cycle, then go to FETCH.
REQ-029 SHALL make HALT and ERR absorbing: only rst leaves them, and all request and enable outputs are 0 there.
REQ-030 SHALL drive halt=1 only in HALT and err=1 only in ERR.
REQ-031 SHALL give these latencies when ready and response are always high: 4 cycles for a non-memory instruction, 6 cycles for a load or store.
REQ-032 SHALL never assert if_req_valid and lsu_req_valid in the same cycle.

Reset
REQ-033 SHALL, while rst is high at a clock edge, enter FETCH, clear lsu_we and the timeout counter, and drive all outputs 0 except state=0.
REQ-034 SHALL let reset mid-transaction abandon any outstanding request; in the first cycle after rst deasserts, if_req_valid=1.

Configuration
REQ-035 SHALL, with YSYX_23060061_BUS_TIMEOUT_EN defined, keep an 8-bit stall counter that is cleared on every state change and increments each cycle spent in FETCH, WAIT_I, MEM_REQ or MEM_WAIT; reaching TIMEOUT_CYCLES SHALL send the FSM to ERR on the next edge.
REQ-036 SHALL, without YSYX_23060061_BUS_TIMEOUT_EN, contain no counter: wait states last indefinitely and err is asserted only for an illegal mem_rw.

Verification
REQ-037 SHALL cover: addi with ready/resp tied high -> states 0,1,2,5,0; one rf_we and one pc_we pulse; 4 cycles.
REQ-038 SHALL cover: lw with lsu_req_ready delayed 3 cycles -> lsu_req_valid held 4 cycles, lsu_we=0, rf_we in WB, 9 cycles total.
REQ-039 SHALL cover: sw (mem_rw=01, reg_write=0) -> lsu_we=1 throughout MEM_REQ, rf_we stays 0, pc_we pulses once.
REQ-040 SHALL cover: ebreak=1 with mem_rw=10 in EXEC -> HALT, halt=1, no lsu_req_valid, outputs frozen for 20 cycles.
REQ-041 SHALL cover: rst pulsed during MEM_WAIT -> next cycle state=0, lsu_req_valid=0, if_req_valid=1 after deassertion.
REQ-042 SHALL cover: with YSYX_23060061_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=16, if_resp_valid held low -> err=1 exactly 17 cycles after entering WAIT_I; without the macro -> err stays 0.

Source files
------------

// File: rtl/ysyx_23060061_core_ctrl.sv
// Multi-cycle core sequencer: fetch, wait for the instruction, execute, optional memory access, write back.
// Optional bus-stall watchdog enabled by defining YSYX_23060061_BUS_TIMEOUT_EN.
module ysyx_23060061_core_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  output logic       if_req_valid,
  input  logic       if_req_ready,
  input  logic       if_resp_valid,
  output logic       inst_we,
  input  logic [1:0] mem_rw,
  input  logic       reg_write,
  input  logic       ebreak,
  output logic       lsu_req_valid,
  output logic       lsu_we,
  input  logic       lsu_req_ready,
  input  logic       lsu_resp_valid,
  output logic       rf_we,
  output logic       pc_we,
  output logic       halt,
  output logic       err,
  output logic [2:0] state
);

  localparam logic [2:0] FETCH    = 3'd0;
  localparam logic [2:0] WAIT_I   = 3'd1;
  localparam logic [2:0] EXEC     = 3'd2;
  localparam logic [2:0] MEM_REQ  = 3'd3;
  localparam logic [2:0] MEM_WAIT = 3'd4;
  localparam logic [2:0] WB       = 3'd5;
  localparam logic [2:0] HALT     = 3'd6;
  localparam logic [2:0] ERR      = 3'd7;

  logic [2:0] stateQ;
  logic [2:0] stateNext;
  logic       lsuWeQ;
  logic       timeoutHit;

  logic isLoad;
  logic isStore;
  logic isIllegal;

  assign isLoad    = (mem_rw == 2'b10);
  assign isStore   = (mem_rw == 2'b01);
  assign isIllegal = (mem_rw == 2'b11);

`ifdef YSYX_23060061_BUS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] stallCnt;
  logic       inWaitState;

  assign inWaitState = (stateQ == FETCH) || (stateQ == WAIT_I) ||
                       (stateQ == MEM_REQ) || (stateQ == MEM_WAIT);
  assign timeoutHit  = inWaitState && (stallCnt == TIMEOUT_LIMIT);

  // Counts consecutive cycles in one wait state; any state change restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= 8'd0;
    end else if (stateNext != stateQ) begin
      stallCnt <= 8'd0;
    end else if (inWaitState) begin
      stallCnt <= stallCnt + 8'd1;
    end
  end
`else
  logic unusedTimeoutParam;

  assign unusedTimeoutParam = (TIMEOUT_CYCLES != 0);
  assign timeoutHit         = 1'b0;
`endif

  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      FETCH:    if (if_req_ready)   stateNext = WAIT_I;
      WAIT_I:   if (if_resp_valid)  stateNext = EXEC;
      EXEC: begin
        if (ebreak)                   stateNext = HALT;
        else if (isIllegal)           stateNext = ERR;
        else if (isLoad || isStore)   stateNext = MEM_REQ;
        else                          stateNext = WB;
      end
      MEM_REQ:  if (lsu_req_ready)  stateNext = MEM_WAIT;
      MEM_WAIT: if (lsu_resp_valid) stateNext = WB;
      WB:                           stateNext = FETCH;
      HALT:                         stateNext = HALT;
      ERR:                          stateNext = ERR;
      default:                      stateNext = ERR;
    endcase
    if (timeoutHit) stateNext = ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= FETCH;
      lsuWeQ <= 1'b0;
    end else begin
      stateQ <= stateNext;
      if (stateQ == EXEC) lsuWeQ <= mem_rw[0];
    end
  end

  // Outputs are forced quiet while rst is high so an in-flight request is dropped at once.
  always_comb begin
    if_req_valid  = 1'b0;
    inst_we       = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_we        = 1'b0;
    rf_we         = 1'b0;
    pc_we         = 1'b0;
    halt          = 1'b0;
    err           = 1'b0;
    state         = FETCH;
    if (!rst) begin
      state = stateQ;
      case (stateQ)
        FETCH:    if_req_valid = 1'b1;
        WAIT_I:   inst_we      = if_resp_valid;
        MEM_REQ: begin
          lsu_req_valid = 1'b1;
          lsu_we        = lsuWeQ;
        end
        MEM_WAIT: lsu_we = lsuWeQ;
        WB: begin
          lsu_we = lsuWeQ;
          pc_we  = 1'b1;
          rf_we  = reg_write;
        end
        HALT:     halt = 1'b1;
        ERR:      err  = 1'b1;
        default:  err  = 1'b0;
      endcase
    end
  end

  ifLsuExclusive: assert property (@(posedge clk) disable iff (rst)
    !(if_req_valid && lsu_req_valid));

  lsuReqHeld: assert property (@(posedge clk) disable iff (rst)
    (lsu_req_valid && !lsu_req_ready) |=> lsu_req_valid);

endmodule

// File: tb/tb_ysyx_23060061_core_ctrl.sv
// Directed bench for ysyx_23060061_core_ctrl: instruction traces, terminal states, reset and bus-stall cases.
module tb_ysyx_23060061_core_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       if_req_valid;
  logic       if_req_ready;
  logic       if_resp_valid;
  logic       inst_we;
  logic [1:0] mem_rw;
  logic       reg_write;
  logic       ebreak;
  logic       lsu_req_valid;
  logic       lsu_we;
  logic       lsu_req_ready;
  logic       lsu_resp_valid;
  logic       rf_we;
  logic       pc_we;
  logic       halt;
  logic       err;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;
  int overlapCnt = 0;

  logic [63:0] traceWord;
  int pcCnt, rfCnt, instCnt, lsuCnt, lsuWeOnes, rfIdx;

  always #5 clk = ~clk;

  ysyx_23060061_core_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_resp_valid(if_resp_valid),
    .inst_we(inst_we), .mem_rw(mem_rw), .reg_write(reg_write), .ebreak(ebreak),
    .lsu_req_valid(lsu_req_valid), .lsu_we(lsu_we), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .rf_we(rf_we), .pc_we(pc_we),
    .halt(halt), .err(err), .state(state)
  );

  always @(negedge clk) if (if_req_valid && lsu_req_valid) overlapCnt++;

  task automatic checkEq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Records one nibble of state per cycle; the DUT is left in the last sampled cycle.
  task automatic runTrace(input int n, input int readyDelay);
    int memReqCycles;
    memReqCycles = 0;
    traceWord = '0;
    pcCnt = 0; rfCnt = 0; instCnt = 0; lsuCnt = 0; lsuWeOnes = 0; rfIdx = -1;
    for (int i = 0; i < n; i++) begin
      if (state == 3'd3) begin
        lsu_req_ready = (memReqCycles >= readyDelay);
        memReqCycles++;
      end else begin
        lsu_req_ready = 1'b1;
      end
      #1;
      traceWord = (traceWord << 4) | 64'(state);
      if (pc_we) pcCnt++;
      if (rf_we) begin rfCnt++; rfIdx = i; end
      if (inst_we) instCnt++;
      if (lsu_req_valid) begin
        lsuCnt++;
        if (lsu_we) lsuWeOnes++;
      end
      if (i < n - 1) step();
    end
  endtask

  initial begin
    int bad;
    int errIdx;
    rst = 1'b1; if_req_ready = 1'b0; if_resp_valid = 1'b0; mem_rw = 2'b00;
    reg_write = 1'b0; ebreak = 1'b0; lsu_req_ready = 1'b0; lsu_resp_valid = 1'b0;
    step(); step(); #1;
    checkEq("rst_state", 64'(state), 0);
    checkEq("rst_outs", {if_req_valid, inst_we, lsu_req_valid, lsu_we, rf_we, pc_we, halt, err}, 0);

    // addi with everything ready
    if_req_ready = 1'b1; if_resp_valid = 1'b1; lsu_resp_valid = 1'b1;
    mem_rw = 2'b00; reg_write = 1'b1; rst = 1'b0; #1;
    checkEq("addi_first_ifv", 64'(if_req_valid), 1);
    runTrace(5, 0);
    checkEq("addi_trace", traceWord, 64'h01250);
    checkEq("addi_pc_we", 64'(pcCnt), 1);
    checkEq("addi_rf_we", 64'(rfCnt), 1);
    checkEq("addi_inst_we", 64'(instCnt), 1);
    checkEq("addi_lsu_vld", 64'(lsuCnt), 0);

    // lw with lsu_req_ready held off for three cycles
    mem_rw = 2'b10; reg_write = 1'b1;
    runTrace(10, 3);
    checkEq("lw_trace", traceWord, 64'h0123333450);
    checkEq("lw_lsu_vld", 64'(lsuCnt), 4);
    checkEq("lw_lsu_we", 64'(lsuWeOnes), 0);
    checkEq("lw_rf_idx", 64'(rfIdx), 8);
    checkEq("lw_pc_we", 64'(pcCnt), 1);

    // sw
    mem_rw = 2'b01; reg_write = 1'b0;
    runTrace(7, 0);
    checkEq("sw_trace", traceWord, 64'h0123450);
    checkEq("sw_lsu_we", 64'(lsuWeOnes), 1);
    checkEq("sw_lsu_vld", 64'(lsuCnt), 1);
    checkEq("sw_rf_we", 64'(rfCnt), 0);
    checkEq("sw_pc_we", 64'(pcCnt), 1);

    // ebreak beats a load
    ebreak = 1'b1; mem_rw = 2'b10; reg_write = 1'b1;
    runTrace(4, 0);
    checkEq("ebreak_trace", traceWord, 64'h0126);
    checkEq("ebreak_lsu_vld", 64'(lsuCnt), 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if_req_ready = i[0]; lsu_req_ready = ~i[0]; lsu_resp_valid = i[1]; if_resp_valid = i[2];
      #1;
      if (state !== 3'd6 ||
          {if_req_valid, inst_we, lsu_req_valid, lsu_we, rf_we, pc_we, halt, err} !== 8'b0000_0010)
        bad++;
    end
    checkEq("halt_frozen", 64'(bad), 0);

    rst = 1'b1; ebreak = 1'b0;
    step(); #1;
    checkEq("halt_rst_state", 64'(state), 0);
    checkEq("halt_rst_outs", {if_req_valid, inst_we, lsu_req_valid, lsu_we, rf_we, pc_we, halt, err}, 0);

    // reset in the middle of a load
    rst = 1'b0; mem_rw = 2'b10; if_req_ready = 1'b1; if_resp_valid = 1'b1;
    lsu_req_ready = 1'b1; lsu_resp_valid = 1'b0; #1;
    for (int i = 0; i < 10 && state != 3'd4; i++) step();
    checkEq("reach_mem_wait", 64'(state), 4);
    rst = 1'b1;
    step(); #1;
    checkEq("midrst_state", 64'(state), 0);
    checkEq("midrst_lsu_vld", 64'(lsu_req_valid), 0);
    rst = 1'b0; #1;
    checkEq("midrst_ifv", 64'(if_req_valid), 1);

    // illegal memory class
    mem_rw = 2'b11; lsu_resp_valid = 1'b1;
    runTrace(4, 0);
    checkEq("illegal_trace", traceWord, 64'h0127);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      if (err !== 1'b1 || halt !== 1'b0 || state !== 3'd7 || if_req_valid !== 1'b0) bad++;
    end
    checkEq("err_sticky", 64'(bad), 0);

    // FETCH waits for if_req_ready
    rst = 1'b1; mem_rw = 2'b00;
    step();
    rst = 1'b0; if_req_ready = 1'b0; if_resp_valid = 1'b0; #1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      if (state !== 3'd0 || if_req_valid !== 1'b1) bad++;
    end
    checkEq("fetch_stall", 64'(bad), 0);

    // instruction response never arrives
    rst = 1'b1;
    step();
    rst = 1'b0; if_req_ready = 1'b1; #1;
    errIdx = -1;
    for (int i = 0; i < 40; i++) begin
      if (err === 1'b1 && errIdx < 0) errIdx = i;
      step(); #1;
    end
`ifdef YSYX_23060061_BUS_TIMEOUT_EN
    checkEq("timeout_idx", 64'(errIdx), 18);
    checkEq("timeout_state", 64'(state), 7);
`else
    checkEq("no_timeout_idx", 64'(errIdx), 64'(-1));
    checkEq("no_timeout_state", 64'(state), 1);
`endif

    checkEq("if_lsu_overlap", 64'(overlapCnt), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
